// File: rtl/bank_addr_gen.sv
// Banked address generator: walks a strided linear sequence
// and splits each address into a low-order-interleaved bank and word.
module bank_addr_gen #(
    parameter  int NBANKS = 32,
    parameter  int NWORDS = 1024,
    parameter  int CW     = 16,
    localparam int BA     = $clog2(NBANKS),
    localparam int WA     = $clog2(NWORDS),
    localparam int LA     = BA + WA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LA-1:0] base,
    input  logic [LA-1:0] stride,
    input  logic [CW-1:0] count,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [BA-1:0] out_bank,
    output logic [WA-1:0] out_word,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LA-1:0] addr_q, addr_d;
    logic [LA-1:0] stride_q, stride_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE: begin
                last_d = 1'b0;
                if (start) begin
                    if (count != '0) begin
                        state_d  = RUN;
                        addr_d   = base;
                        stride_d = stride;
                        rem_d    = count;
                        last_d   = (count == CW'(1));
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                        last_d  = 1'b0;
                    end else begin
                        addr_d = addr_q + stride_q;
                        rem_d  = rem_q - CW'(1);
                        last_d = (rem_q == CW'(2));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                last_d  = 1'b0;
            end
        endcase
        valid_d = (state_d == RUN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_bank  = addr_q[BA-1:0];
    assign out_word  = addr_q[LA-1:BA];
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bank_addr_gen.sv
// Testbench for bank_addr_gen: directed cases with literal expectations
// plus random traffic checked every cycle against a sequence-level model.
module tb_bank_addr_gen;

    localparam int NB = 32;
    localparam int NW = 1024;
    localparam int CW = 16;
    localparam int BA = 5;
    localparam int WA = 10;
    localparam int LA = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LA-1:0] base;
    logic [LA-1:0] stride;
    logic [CW-1:0] count;
    logic          out_ready;
    logic          out_valid;
    logic [BA-1:0] out_bank;
    logic [WA-1:0] out_word;
    logic          out_last;
    logic          busy;
    logic          done;

    bank_addr_gen #(.NBANKS(NB), .NWORDS(NW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base),
        .stride(stride), .count(count), .out_ready(out_ready),
        .out_valid(out_valid), .out_bank(out_bank),
        .out_word(out_word), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Sequence-level model: phase 0 idle, 1 emitting, 2 finished.
    // Address i of a sequence is (base + i*stride) mod 2^LA.
    int     ph = 0;
    longint m_base = 0, m_stride = 0, m_n = 0, m_i = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
        end else if (ph == 0) begin
            if (start) begin
                if (count != 0) begin
                    ph = 1;
                    m_base = base;
                    m_stride = stride;
                    m_n = count;
                    m_i = 0;
                end else begin
                    ph = 2;
                end
            end
        end else if (ph == 1) begin
            if (out_ready) begin
                if (m_i == m_n - 1) ph = 2;
                else m_i++;
            end
        end else begin
            ph = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        longint e;
        if (chk_en) begin
            e = (m_base + m_i * m_stride) % (longint'(1) << LA);
            check("valid", out_valid, ph == 1);
            check("busy", busy, ph != 0);
            check("done", done, ph == 2);
            check("last", out_last, (ph == 1) && (m_i == m_n - 1));
            if (ph == 1) begin
                check("bank", out_bank, e % NB);
                check("word", out_word, e / NB);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go(input int b, input int s, input int c);
        base = LA'(b);
        stride = LA'(s);
        count = CW'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic exp_addr(input int b, input int w, input bit l);
        check("lit_valid", out_valid, 1);
        check("lit_bank", out_bank, b);
        check("lit_word", out_word, w);
        check("lit_last", out_last, l);
    endtask

    task automatic exp_done();
        check("lit_done", done, 1);
        check("lit_busy", busy, 1);
        check("lit_novalid", out_valid, 0);
        tick();
        check("lit_done_end", done, 0);
        check("lit_idle", busy, 0);
    endtask

    initial begin
        int banks[4];
        int words[4];
        int cnt;
        bit seen;
        banks = '{30, 31, 0, 1};
        words = '{0, 0, 1, 1};
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        stride = '0;
        count = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", out_valid, 0);
        check("rst_bank", out_bank, 0);
        check("rst_word", out_word, 0);
        check("rst_busy", busy, 0);
        tick();

        // Interleave across the bank boundary.
        go(30, 1, 4);
        for (int k = 0; k < 4; k++) begin
            exp_addr(banks[k], words[k], k == 3);
            tick();
        end
        exp_done();

        // Stall on the second address.
        go(5, 32, 3);
        exp_addr(5, 0, 0);
        tick();
        exp_addr(5, 1, 0);
        out_ready = 1'b0;
        tick();
        exp_addr(5, 1, 0);
        tick();
        exp_addr(5, 1, 0);
        out_ready = 1'b1;
        tick();
        exp_addr(5, 2, 1);
        tick();
        exp_done();

        // Zero-length request.
        go(7, 1, 0);
        exp_done();
        check("zero_novalid", out_valid, 0);

        // Wrap past the top of the address space.
        go(32767, 2, 2);
        exp_addr(31, 1023, 0);
        tick();
        exp_addr(1, 0, 1);
        tick();
        exp_done();

        // Reset in the middle of a sequence.
        go(100, 3, 8);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_nodone", done, 0);
        go(200, 1, 1);
        exp_addr(8, 6, 1);
        tick();
        exp_done();

        // Start held high: back-to-back sequences.
        base = LA'(10);
        stride = LA'(1);
        count = CW'(2);
        start = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            exp_addr(10, 0, 0);
            tick();
            exp_addr(11, 0, 1);
            tick();
            check("b2b_done", done, 1);
            if (r == 1) start = 1'b0;
            tick();
            check("b2b_idle", busy, 0);
            tick();
        end
        check("b2b_stop", out_valid, 0);

        // Maximum count.
        go(0, 1, 65535);
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 70000) begin
            tick();
            cnt++;
            if (done) seen = 1'b1;
        end
        check("maxcnt_len", cnt, 65535);
        tick();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom % 4) != 0;
            start = ($urandom % 3) == 0;
            base = LA'($urandom);
            stride = ($urandom % 5 == 0) ? '0 : LA'($urandom);
            count = ($urandom % 8 == 0) ? '0 : CW'($urandom_range(1, 12));
            rst = ($urandom % 300) == 0;
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
